// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: generates MAC address pairs over an IN_DIM x IN_DIM input
// with a K_DIM x K_DIM filter, writes each output pixel, then steps a display through them.
module conv_seq_ctrl #(
    parameter int IN_DIM = 4,
    parameter int K_DIM  = 3,
    parameter int DWELL  = 100000000,
    localparam int O_DIM = IN_DIM - K_DIM + 1,
    localparam int A_W   = ($clog2(IN_DIM*IN_DIM) > 1) ? $clog2(IN_DIM*IN_DIM) : 1,
    localparam int B_W   = ($clog2(K_DIM*K_DIM) > 1) ? $clog2(K_DIM*K_DIM) : 1,
    localparam int W_W   = ($clog2(O_DIM*O_DIM) > 1) ? $clog2(O_DIM*O_DIM) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           mode,
    output logic [A_W-1:0] addr_a,
    output logic [B_W-1:0] addr_b,
    output logic           mac_clr,
    output logic           mac_en,
    output logic           wr_en,
    output logic [W_W-1:0] wr_addr,
    output logic           dis_en,
    output logic [W_W-1:0] dis_addr,
    output logic           busy,
    output logic           done
);
    localparam int RC_W = ($clog2(O_DIM) > 1) ? $clog2(O_DIM) : 1;
    localparam int IJ_W = ($clog2(K_DIM) > 1) ? $clog2(K_DIM) : 1;
    localparam int D_W  = ($clog2(DWELL) > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_WRITE, S_DISP, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [RC_W-1:0] r_q, r_d, c_q, c_d;
    logic [IJ_W-1:0] i_q, i_d, j_q, j_d;
    logic            mode_q, mode_d;
    logic [D_W-1:0]  dcnt_q, dcnt_d;
    logic [W_W-1:0]  daddr_q, daddr_d;

    logic [A_W-1:0]  addr_a_q, addr_a_d;
    logic [B_W-1:0]  addr_b_q, addr_b_d;
    logic            mac_clr_q, mac_clr_d, mac_en_q, mac_en_d, wr_en_q, wr_en_d;
    logic [W_W-1:0]  wr_addr_q, wr_addr_d, dis_addr_q, dis_addr_d;
    logic            dis_en_q, dis_en_d, busy_q, busy_d, done_q, done_d;

    // Sequencing: taps j-fastest, outputs c-fastest, display dwell per result.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        i_d     = i_q;
        j_d     = j_q;
        mode_d  = mode_q;
        dcnt_d  = dcnt_q;
        daddr_d = daddr_q;
        case (state_q)
            S_IDLE: if (start) begin
                mode_d  = mode;
                r_d     = '0;
                c_d     = '0;
                i_d     = '0;
                j_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                if (j_q == IJ_W'(K_DIM-1)) begin
                    j_d = '0;
                    if (i_q == IJ_W'(K_DIM-1)) begin
                        i_d     = '0;
                        state_d = S_WRITE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            S_WRITE: begin
                state_d = S_MAC;
                if (c_q == RC_W'(O_DIM-1)) begin
                    c_d = '0;
                    if (r_q == RC_W'(O_DIM-1)) begin
                        r_d     = '0;
                        dcnt_d  = '0;
                        daddr_d = '0;
                        state_d = S_DISP;
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            S_DISP: begin
                if (dcnt_q == D_W'(DWELL-1)) begin
                    dcnt_d = '0;
                    if (daddr_q == W_W'(O_DIM*O_DIM-1)) state_d = S_DONE;
                    else                                daddr_d = daddr_q + 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they track the state register.
    always_comb begin
        addr_a_d   = '0;
        addr_b_d   = '0;
        mac_clr_d  = 1'b0;
        mac_en_d   = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = '0;
        dis_en_d   = 1'b0;
        dis_addr_d = '0;
        busy_d     = (state_d != S_IDLE);
        done_d     = 1'b0;
        case (state_d)
            S_MAC: begin
                addr_a_d  = A_W'((32'(r_d) + 32'(i_d)) * IN_DIM + 32'(c_d) + 32'(j_d));
                addr_b_d  = mode_d ? B_W'(32'(i_d) * K_DIM + 32'(j_d))
                                   : B_W'(K_DIM*K_DIM - 1 - (32'(i_d) * K_DIM + 32'(j_d)));
                mac_en_d  = 1'b1;
                mac_clr_d = (i_d == '0) && (j_d == '0);
            end
            S_WRITE: begin
                wr_en_d   = 1'b1;
                wr_addr_d = W_W'(32'(r_d) * O_DIM + 32'(c_d));
            end
            S_DISP: begin
                dis_en_d   = 1'b1;
                dis_addr_d = daddr_d;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            r_q        <= '0;
            c_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            mode_q     <= 1'b0;
            dcnt_q     <= '0;
            daddr_q    <= '0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            mac_clr_q  <= 1'b0;
            mac_en_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            dis_en_q   <= 1'b0;
            dis_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            i_q        <= i_d;
            j_q        <= j_d;
            mode_q     <= mode_d;
            dcnt_q     <= dcnt_d;
            daddr_q    <= daddr_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            mac_clr_q  <= mac_clr_d;
            mac_en_q   <= mac_en_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            dis_en_q   <= dis_en_d;
            dis_addr_q <= dis_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign addr_a   = addr_a_q;
    assign addr_b   = addr_b_q;
    assign mac_clr  = mac_clr_q;
    assign mac_en   = mac_en_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign dis_en   = dis_en_q;
    assign dis_addr = dis_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: three configurations (4/3 dwell 3, 5/5 dwell 1, 3/1 dwell 1)
// checked every cycle against an arithmetic timeline model, plus literal spot values.
module tb_conv_seq_ctrl;
    typedef struct packed {
        logic [31:0] a, b, clr, en, wr, wa, dis, da, busy, done;
    } exp_t;

    localparam int PIN[3] = '{4, 5, 3};
    localparam int PK[3]  = '{3, 5, 1};
    localparam int PD[3]  = '{3, 1, 1};

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    // Instance 0: 4/3, dwell 3
    logic [3:0] a0; logic [3:0] b0; logic [1:0] wa0, da0;
    logic clr0, en0, wr0, dis0, busy0, done0;
    conv_seq_ctrl #(.IN_DIM(4), .K_DIM(3), .DWELL(3)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .addr_a(a0), .addr_b(b0),
        .mac_clr(clr0), .mac_en(en0), .wr_en(wr0), .wr_addr(wa0), .dis_en(dis0),
        .dis_addr(da0), .busy(busy0), .done(done0));

    // Instance 1: 5/5, dwell 1 (single output)
    logic [4:0] a1; logic [4:0] b1; logic [0:0] wa1, da1;
    logic clr1, en1, wr1, dis1, busy1, done1;
    conv_seq_ctrl #(.IN_DIM(5), .K_DIM(5), .DWELL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .addr_a(a1), .addr_b(b1),
        .mac_clr(clr1), .mac_en(en1), .wr_en(wr1), .wr_addr(wa1), .dis_en(dis1),
        .dis_addr(da1), .busy(busy1), .done(done1));

    // Instance 2: 3/1, dwell 1 (single-tap filter)
    logic [3:0] a2; logic [0:0] b2; logic [3:0] wa2, da2;
    logic clr2, en2, wr2, dis2, busy2, done2;
    conv_seq_ctrl #(.IN_DIM(3), .K_DIM(1), .DWELL(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .addr_a(a2), .addr_b(b2),
        .mac_clr(clr2), .mac_en(en2), .wr_en(wr2), .wr_addr(wa2), .dis_en(dis2),
        .dis_addr(da2), .busy(busy2), .done(done2));

    function automatic int total(int n);
        int o = PIN[n] - PK[n] + 1;
        return o*o*(PK[n]*PK[n] + 1) + o*o*PD[n] + 1;
    endfunction

    // Expected outputs k cycles after the accepting edge (k=0: idle).
    function automatic exp_t model(int n, int k, bit md);
        exp_t e = '0;
        int in = PIN[n], kd = PK[n], dw = PD[n];
        int o = in - kd + 1, per = kd*kd + 1, comp = o*o*per;
        int p, t;
        if (k == 0) return e;
        e.busy = 1;
        if (k <= comp) begin
            p = (k-1) / per;
            t = (k-1) % per;
            if (t < kd*kd) begin
                e.en  = 1;
                e.clr = (t == 0) ? 1 : 0;
                e.a   = 32'((p/o + t/kd)*in + p%o + t%kd);
                e.b   = md ? 32'(t) : 32'(kd*kd - 1 - t);
            end else begin
                e.wr = 1;
                e.wa = 32'(p);
            end
        end else if (k <= comp + o*o*dw) begin
            e.dis = 1;
            e.da  = 32'((k - comp - 1) / dw);
        end else begin
            e.done = 1;
        end
        return e;
    endfunction

    int  k[3];
    bit  md[3];
    always @(posedge clk or negedge rst_n) begin
        for (int n = 0; n < 3; n++) begin
            if (!rst_n) begin
                k[n] <= 0;
            end else if (k[n] > 0) begin
                k[n] <= (k[n] == total(n)) ? 0 : k[n] + 1;
            end else if (start) begin
                k[n]  <= 1;
                md[n] <= mode;
            end
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cmp(int n, exp_t g);
        exp_t e = model(n, k[n], md[n]);
        string s = $sformatf("u%0d k=%0d", n, k[n]);
        chk({s, " addr_a"},   g.a,    e.a);
        chk({s, " addr_b"},   g.b,    e.b);
        chk({s, " mac_clr"},  g.clr,  e.clr);
        chk({s, " mac_en"},   g.en,   e.en);
        chk({s, " wr_en"},    g.wr,   e.wr);
        chk({s, " wr_addr"},  g.wa,   e.wa);
        chk({s, " dis_en"},   g.dis,  e.dis);
        chk({s, " dis_addr"}, g.da,   e.da);
        chk({s, " busy"},     g.busy, e.busy);
        chk({s, " done"},     g.done, e.done);
    endtask

    always @(negedge clk) begin
        cmp(0, {32'(a0), 32'(b0), 32'(clr0), 32'(en0), 32'(wr0), 32'(wa0), 32'(dis0), 32'(da0), 32'(busy0), 32'(done0)});
        cmp(1, {32'(a1), 32'(b1), 32'(clr1), 32'(en1), 32'(wr1), 32'(wa1), 32'(dis1), 32'(da1), 32'(busy1), 32'(done1)});
        cmp(2, {32'(a2), 32'(b2), 32'(clr2), 32'(en2), 32'(wr2), 32'(wa2), 32'(dis2), 32'(da2), 32'(busy2), 32'(done2)});
    end

    // One run: start with md, optional mid-run start with toggled mode, optional reset at rst_at.
    task automatic run(int id, bit m, int ncyc, bit poke, int rst_at);
        @(negedge clk); #1;
        start = 1'b1;
        mode  = m;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(negedge clk);
            if (id == 0) begin
                case (cyc)
                    1:  begin chk("r0 c1 addr_a", 32'(a0), 0); chk("r0 c1 addr_b", 32'(b0), 8);
                              chk("r0 c1 mac_clr", 32'(clr0), 1); chk("u2 c1 clr&en", 32'(clr2 & en2), 1); end
                    2:  begin chk("r0 c2 addr_a", 32'(a0), 1); chk("r0 c2 mac_clr", 32'(clr0), 0); end
                    4:  chk("r0 c4 addr_a", 32'(a0), 4);
                    9:  begin chk("r0 c9 addr_a", 32'(a0), 10); chk("r0 c9 addr_b", 32'(b0), 0); end
                    10: begin chk("r0 c10 wr_en", 32'(wr0), 1); chk("r0 c10 wr_addr", 32'(wa0), 0); end
                    18: chk("u2 c18 wr_addr", 32'(wa2), 8);
                    20: chk("r0 c20 wr_addr", 32'(wa0), 1);
                    25: begin chk("u1 c25 addr_a", 32'(a1), 24); chk("u1 c25 addr_b", 32'(b1), 0); end
                    26: chk("u1 c26 wr_en", 32'(wr1), 1);
                    40: chk("r0 c40 wr_addr", 32'(wa0), 3);
                    41: begin chk("r0 c41 dis_en", 32'(dis0), 1); chk("r0 c41 dis_addr", 32'(da0), 0); end
                    44: chk("r0 c44 dis_addr", 32'(da0), 1);
                    52: chk("r0 c52 dis_addr", 32'(da0), 3);
                    53: chk("r0 c53 done", 32'(done0), 1);
                    54: begin chk("r0 c54 busy", 32'(busy0), 0); chk("r0 c54 done", 32'(done0), 0); end
                    default: ;
                endcase
            end else if (id == 1) begin
                case (cyc)
                    11: begin chk("r1 c11 addr_a", 32'(a0), 1); chk("r1 c11 addr_b", 32'(b0), 0); end
                    15: begin chk("r1 c15 addr_a", 32'(a0), 6); chk("r1 c15 addr_b", 32'(b0), 4); end
                    19: begin chk("r1 c19 addr_a", 32'(a0), 11); chk("r1 c19 addr_b", 32'(b0), 8); end
                    53: chk("r1 c53 done", 32'(done0), 1);
                    default: ;
                endcase
            end else if (id == 3 && cyc == 10) begin
                chk("r3 c10 wr_en", 32'(wr0), 1);
                chk("r3 c10 wr_addr", 32'(wa0), 0);
            end
            if (cyc == rst_at - 1) begin
                #1 rst_n = 1'b0;
                #1;
                chk("rst busy", 32'(busy0), 0);
                chk("rst mac_en", 32'(en0), 0);
                chk("rst addr_a", 32'(a0), 0);
                chk("rst wr_en", 32'(wr0), 0);
                break;
            end
            #1;
            if (cyc == 1) start = 1'b0;
            if (poke && cyc == 5) begin start = 1'b1; mode = ~m; end
            if (poke && cyc == 6) start = 1'b0;
        end
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy0), 0);
        chk("reset addr_a", 32'(a0), 0);
        #1 rst_n = 1'b1;
        run(0, 1'b0, 60, 1'b0, 0);
        run(1, 1'b1, 60, 1'b1, 0);
        run(2, 1'b0, 30, 1'b0, 15);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        run(3, 1'b0, 60, 1'b0, 0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
